// File: rtl/opcode_pkg.sv
// rtl/opcode_pkg.sv - opcode enum and helpers shared by the execute unit
//
// Purpose: alu_op_t opcode encoding plus small classification helpers.
// Ports:   none (package).
package opcode_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11
  } alu_op_t;

  function automatic logic is_mul(alu_op_t op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

  // Codes 12..15 have no operation assigned.
  function automatic logic is_legal(logic [3:0] op);
    return op <= 4'd11;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative radix-2 unsigned multiplier
//
// Purpose: alu_mul_iter computes a*b over exactly WIDTH cycles using a
//          shift-add over a 2*WIDTH accumulator.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           load operands and begin a multiply
//   i_a, i_b          operands (captured on i_start)
//   o_done            high during the final iteration cycle
//   o_prod            full 2*WIDTH product, valid while o_done is high
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_prod
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic               busy;
  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     sum;

  // The multiplier sits in the low half and is consumed LSB first; the
  // partial sum grows in the high half with one extra carry bit that lands
  // back in the accumulator after the right shift.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  // The product is taken from the next-state value so the owner can latch
  // it on the same edge that retires the last iteration.
  assign o_done = busy && (cnt == CNT_LAST);
  assign o_prod = acc_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (i_start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= i_a;
      acc   <= {{WIDTH{1'b0}}, i_b};
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + SHW'(1);
      if (cnt == CNT_LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked execute unit with iterative multiply
//
// Purpose: registered ALU with valid/ready on both sides; base ops finish
//          in one cycle, MUL/MULHU take WIDTH cycles, illegal ops flag o_err.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid, o_ready      request handshake
//   i_a, i_b, i_op        operands and opcode, captured on acceptance
//   o_valid, i_ready      result handshake
//   o_res, o_err          result and illegal-opcode flag
module alu_seq
  import opcode_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_err
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic               accept;
  logic               req_mul;
  logic               start_mul;
  logic               mul_hi;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   base_res;

  function automatic logic [WIDTH-1:0] base_op(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [SHW-1:0] shamt;
    shamt = b[SHW-1:0];
    case (op)
      OP_ADD:  base_op = a + b;
      OP_SUB:  base_op = a - b;
      OP_SLL:  base_op = a << shamt;
      OP_SLT:  base_op = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: base_op = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  base_op = a ^ b;
      OP_SRL:  base_op = a >> shamt;
      OP_SRA:  base_op = $unsigned($signed(a) >>> shamt);
      OP_OR:   base_op = a | b;
      OP_AND:  base_op = a & b;
      // Multiplies come from the iterative unit; illegal codes read as zero.
      default: base_op = '0;
    endcase
  endfunction

  assign base_res  = base_op(i_op, i_a, i_b);
  assign req_mul   = is_mul(alu_op_t'(i_op));

  // Ready only depends on state and the consumer, never on the request.
  assign o_ready   = !i_rst && ((state == IDLE) || ((state == DONE) && i_ready));
  assign o_valid   = (state == DONE);
  assign accept    = i_valid && o_ready;
  assign start_mul = accept && req_mul;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (start_mul),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_done  (mul_done),
    .o_prod  (mul_prod)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      o_res  <= '0;
      o_err  <= 1'b0;
      mul_hi <= 1'b0;
    end else if (accept) begin
      // Acceptance in DONE doubles as the transfer of the held result.
      if (req_mul) begin
        state  <= BUSY;
        mul_hi <= (i_op == OP_MULHU);
      end else begin
        state <= DONE;
        o_res <= base_res;
        o_err <= !is_legal(i_op);
      end
    end else begin
      case (state)
        BUSY: begin
          if (mul_done) begin
            state <= DONE;
            o_res <= mul_hi ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];
            o_err <= 1'b0;
          end
        end
        DONE: begin
          if (i_ready) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH 32 and 8
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        i_valid, i_ready;
  logic [31:0] i_a, i_b;
  logic [3:0]  i_op;
  logic        o_valid, o_ready, o_err;
  logic [31:0] o_res;

  logic        v8, r8, o_valid8, o_ready8, o_err8;
  logic [7:0]  a8, b8, o_res8;
  logic [3:0]  op8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  alu_seq #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_op(i_op), .o_valid(o_valid),
    .i_ready(i_ready), .o_res(o_res), .o_err(o_err)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(o_ready8),
    .i_a(a8), .i_b(b8), .i_op(op8), .o_valid(o_valid8),
    .i_ready(r8), .o_res(o_res8), .o_err(o_err8)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference semantics straight from the opcode definitions, in 64-bit
  // arithmetic masked down to w bits. Returns {err, result}.
  function automatic logic [64:0] ref_alu(input int w, input logic [3:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, r, sh;
    longint      sa, sb;
    logic        e;
    mask = (64'd1 << w) - 64'd1;
    sh   = b % 64'(w);
    sa   = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    e    = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a << sh;
      4'd3:  r = 64'(sa < sb);
      4'd4:  r = 64'(a < b);
      4'd5:  r = a ^ b;
      4'd6:  r = a >> sh;
      4'd7:  r = 64'(sa >>> sh);
      4'd8:  r = a | b;
      4'd9:  r = a & b;
      4'd10: r = a * b;
      4'd11: r = (a * b) >> w;
      default: begin r = 64'd0; e = 1'b1; end
    endcase
    return {e, r & mask};
  endfunction

  // Abstract model of the 32-bit unit: one pending result, a countdown of
  // multiply cycles left, and the single presented result.
  bit          m_valid, m_err, m_acc;
  logic [63:0] m_res, m_pend;
  int          m_wait;
  logic [64:0] rr;
  bit          m_rdy;

  initial begin
    m_valid = 0; m_err = 0; m_acc = 0; m_res = 0; m_pend = 0; m_wait = 0;
  end

  always @(posedge clk) begin
    m_rdy = !rst && (m_wait == 0) && (!m_valid || i_ready);
    m_acc = m_rdy && i_valid;
    if (rst) begin
      m_valid = 0; m_wait = 0; m_res = 0; m_err = 0;
    end else begin
      if (m_valid && i_ready) m_valid = 0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_valid = 1; m_res = m_pend; m_err = 0; end
      end
      if (m_acc) begin
        rr = ref_alu(32, i_op, 64'(i_a), 64'(i_b));
        if (i_op == 4'd10 || i_op == 4'd11) begin
          m_wait = 32; m_pend = rr[63:0];
        end else begin
          m_valid = 1; m_res = rr[63:0]; m_err = rr[64];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_valid", 64'(o_valid), 64'(m_valid));
      check("cmp_ready", 64'(o_ready), 64'(!rst && m_wait == 0 && (!m_valid || i_ready)));
      if (m_valid) begin
        check("cmp_res", 64'(o_res), m_res);
        check("cmp_err", 64'(o_err), 64'(m_err));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 0;
    i_valid = 1; i_op = op; i_a = a; i_b = b;
    for (int n = 0; n < 100 && !done; n++) begin
      @(posedge clk); #1;
      if (m_acc) done = 1;
    end
    i_valid = 0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL issue_timeout: op %0d not accepted within 100 cycles", op);
    end
  endtask

  task automatic wait_valid32(input string name, output int lat);
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      lat++;
      if (o_valid) break;
      check({name, "_busy_ready"}, 64'(o_ready), 64'd0);
    end
  endtask

  task automatic run8(input string name, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
    int lat;
    check({name, "_ready"}, 64'(o_ready8), 64'd1);
    v8 = 1; op8 = op; a8 = a; b8 = b;
    next_cycle();
    v8 = 0;
    lat = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      lat++;
      if (o_valid8) break;
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_res"}, 64'(o_res8), 64'(exp));
    check({name, "_err"}, 64'(o_err8), 64'd0);
    next_cycle();
  endtask

  logic [3:0]  t_op  [6] = '{4'd0, 4'd1, 4'd7, 4'd3, 4'd4, 4'd13};
  logic [31:0] t_a   [6] = '{32'd5, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd77};
  logic [31:0] t_b   [6] = '{32'd3, 32'd5, 32'h21, 32'd1, 32'd1, 32'd9};
  logic [31:0] t_exp [6] = '{32'd8, 32'hFFFF_FFFE, 32'hC000_0000, 32'd1, 32'd0, 32'd0};
  logic        t_err [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int lat;
    int n_acc;
    rst = 1; i_valid = 0; i_ready = 1; i_op = 0; i_a = 0; i_b = 0;
    v8 = 0; r8 = 1; op8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_res", 64'(o_res), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_ready_low", 64'(o_ready), 64'd0);
    check("rst_valid8", 64'(o_valid8), 64'd0);
    rst = 0;
    chk_en = 1;
    @(negedge clk);
    check("ready_after_rst", 64'(o_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      @(negedge clk);
      check("dir_valid", 64'(o_valid), 64'd1);
      check("dir_res", 64'(o_res), 64'(t_exp[i]));
      check("dir_err", 64'(o_err), 64'(t_err[i]));
    end

    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid32("mulhu", lat);
    check("mulhu_lat", 64'(lat), 64'd33);
    check("mulhu_res", 64'(o_res), 64'hFFFF_FFFE);
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid32("mul", lat);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_res", 64'(o_res), 64'h1);

    next_cycle();
    i_ready = 0;
    issue(4'd0, 32'd7, 32'd8);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_res", 64'(o_res), 64'd15);
      check("bp_hold_ready", 64'(o_ready), 64'd0);
      check("bp_hold_valid", 64'(o_valid), 64'd1);
    end
    next_cycle();
    i_valid = 1; i_op = 4'd0; i_a = 32'd1; i_b = 32'd1; i_ready = 1;
    next_cycle();
    i_valid = 0;
    @(negedge clk);
    check("bp_release_res", 64'(o_res), 64'd2);

    next_cycle();
    n_acc = 0;
    for (int i = 0; i < 100; i++) begin
      i_valid = 1;
      i_op = 4'($urandom_range(0, 9));
      i_a = $urandom;
      i_b = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      @(negedge clk);
      if (o_ready) n_acc++;
      next_cycle();
    end
    i_valid = 0;
    check("stream_accepts", 64'(n_acc), 64'd100);

    issue(4'd10, 32'd123, 32'd456);
    repeat (9) next_cycle();
    rst = 1;
    @(negedge clk);
    check("rst_busy_ready", 64'(o_ready), 64'd0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    check("abort_valid", 64'(o_valid), 64'd0);
    check("abort_ready", 64'(o_ready), 64'd1);
    repeat (40) begin
      @(negedge clk);
      check("abort_no_stale", 64'(o_valid), 64'd0);
    end
    issue(4'd0, 32'd2, 32'd2);
    @(negedge clk);
    check("post_abort_add", 64'(o_res), 64'd4);

    next_cycle();
    run8("w8_mul", 4'd10, 8'h10, 8'h10, 8'h00, 9);
    run8("w8_mulhu", 4'd11, 8'h10, 8'h10, 8'h01, 9);
    run8("w8_sll", 4'd2, 8'h03, 8'h0F, 8'h80, 1);
    run8("w8_sra", 4'd7, 8'h90, 8'h0A, 8'hE4, 1);

    repeat (3) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
